// File: rtl/msi_snoop_ctrl.sv
// Coherence initiator for a 2-CPU MSI system: snoops the peer cache, writes back or
// invalidates/downgrades its copy, fetches the line and fills the local cache.
// Optional build macro C2C_XFER_EN: forward a peer MODIFIED line directly into the fill.
module msi_snoop_ctrl #(
    parameter int SNOOP_LAT   = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [10:0] req_addr,
    input  logic        req_wr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_search,
    output logic [10:0] BOCI,
    output logic        invalidate_from_other_cpu,
    output logic        downgrade_other,
    input  logic        snoop_found,
    input  logic [1:0]  snoop_state,
    input  logic [63:0] snoop_data,
    output logic        mem_re,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_rdy,
    input  logic [63:0] mem_rdata,
    output logic        fill_we,
    output logic [10:0] fill_addr,
    output logic [63:0] fill_data,
    output logic [1:0]  fill_state
);

    localparam logic [1:0] ST_SHARED   = 2'd1;
    localparam logic [1:0] ST_MODIFIED = 2'd2;
    localparam logic [2:0] LAT_LOAD    = 3'(SNOOP_LAT - 1);
    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

`ifdef C2C_XFER_EN
    localparam logic C2C_EN = 1'b1;
`else
    localparam logic C2C_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SNOOP     = 4'd1,
        S_DECIDE    = 4'd2,
        S_WB        = 4'd3,
        S_INVAL     = 4'd4,
        S_DOWNGRADE = 4'd5,
        S_MEM_RD    = 4'd6,
        S_FILL      = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    // Peer copy counts only when found and in a legal valid state (SHARED/MODIFIED).
    function automatic logic peer_in_state(input logic found, input logic [1:0] st,
                                           input logic [1:0] want);
        peer_in_state = found && (st == want);
    endfunction

    state_t      state_r;
    logic [2:0]  lat_cnt_r;
    logic [7:0]  wait_cnt_r;
    logic        req_wr_r;
    logic        peer_found_r;
    logic [1:0]  peer_state_r;
    logic [63:0] peer_data_r;

    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        cpu_search_r;
    logic [10:0] boci_r;
    logic        inval_r;
    logic        downgrade_r;
    logic        mem_re_r;
    logic        mem_we_r;
    logic [10:0] mem_addr_r;
    logic [63:0] mem_wdata_r;
    logic        fill_we_r;
    logic [10:0] fill_addr_r;
    logic [63:0] fill_data_r;
    logic [1:0]  fill_state_r;

    logic        peer_mod_s;
    logic        peer_shr_s;
    logic        forward_s;
    logic [1:0]  fill_state_s;
    logic [7:0]  wait_nxt_s;
    logic        timeout_s;

    // Decode the sampled peer state and derive the fill attributes.
    always_comb begin
        peer_mod_s   = peer_in_state(peer_found_r, peer_state_r, ST_MODIFIED);
        peer_shr_s   = peer_in_state(peer_found_r, peer_state_r, ST_SHARED);
        forward_s    = peer_mod_s && C2C_EN;
        wait_nxt_s   = wait_cnt_r + 8'd1;
        timeout_s    = (wait_nxt_s == TIMEOUT_LIM);
        if (req_wr_r) begin
            fill_state_s = ST_MODIFIED;
        end else begin
            fill_state_s = ST_SHARED;
        end
    end

    // Transaction sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            lat_cnt_r    <= 3'd0;
            wait_cnt_r   <= 8'd0;
            req_wr_r     <= 1'b0;
            peer_found_r <= 1'b0;
            peer_state_r <= 2'd0;
            peer_data_r  <= 64'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            cpu_search_r <= 1'b0;
            boci_r       <= 11'd0;
            inval_r      <= 1'b0;
            downgrade_r  <= 1'b0;
            mem_re_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 11'd0;
            mem_wdata_r  <= 64'd0;
            fill_we_r    <= 1'b0;
            fill_addr_r  <= 11'd0;
            fill_data_r  <= 64'd0;
            fill_state_r <= 2'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req) begin
                        req_wr_r     <= req_wr;
                        busy_r       <= 1'b1;
                        boci_r       <= req_addr;
                        mem_addr_r   <= req_addr;
                        fill_addr_r  <= req_addr;
                        cpu_search_r <= 1'b1;
                        lat_cnt_r    <= LAT_LOAD;
                        state_r      <= S_SNOOP;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SNOOP: begin
                    if (lat_cnt_r == 3'd0) begin
                        cpu_search_r <= 1'b0;
                        peer_found_r <= snoop_found;
                        peer_state_r <= snoop_state;
                        peer_data_r  <= snoop_data;
                        state_r      <= S_DECIDE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 3'd1;
                    end
                end
                S_DECIDE: begin
                    wait_cnt_r <= 8'd0;
                    if (peer_mod_s) begin
                        mem_we_r    <= 1'b1;
                        mem_wdata_r <= peer_data_r;
                        state_r     <= S_WB;
                    end else if (peer_shr_s && req_wr_r) begin
                        inval_r <= 1'b1;
                        state_r <= S_INVAL;
                    end else begin
                        mem_re_r <= 1'b1;
                        state_r  <= S_MEM_RD;
                    end
                end
                S_WB: begin
                    // mem_rdy arriving on the timeout cycle still completes normally.
                    if (mem_rdy) begin
                        mem_we_r <= 1'b0;
                        if (req_wr_r) begin
                            inval_r <= 1'b1;
                            state_r <= S_INVAL;
                        end else begin
                            downgrade_r <= 1'b1;
                            state_r     <= S_DOWNGRADE;
                        end
                    end else if (timeout_s) begin
                        mem_we_r <= 1'b0;
                        err_r    <= 1'b1;
                        state_r  <= S_DONE;
                    end else begin
                        wait_cnt_r <= wait_nxt_s;
                    end
                end
                S_INVAL, S_DOWNGRADE: begin
                    inval_r     <= 1'b0;
                    downgrade_r <= 1'b0;
                    if (forward_s) begin
                        fill_we_r    <= 1'b1;
                        fill_data_r  <= peer_data_r;
                        fill_state_r <= fill_state_s;
                        state_r      <= S_FILL;
                    end else begin
                        mem_re_r   <= 1'b1;
                        wait_cnt_r <= 8'd0;
                        state_r    <= S_MEM_RD;
                    end
                end
                S_MEM_RD: begin
                    if (mem_rdy) begin
                        mem_re_r     <= 1'b0;
                        fill_we_r    <= 1'b1;
                        fill_data_r  <= mem_rdata;
                        fill_state_r <= fill_state_s;
                        state_r      <= S_FILL;
                    end else if (timeout_s) begin
                        mem_re_r <= 1'b0;
                        err_r    <= 1'b1;
                        state_r  <= S_DONE;
                    end else begin
                        wait_cnt_r <= wait_nxt_s;
                    end
                end
                S_FILL: begin
                    fill_we_r <= 1'b0;
                    done_r    <= 1'b1;
                    state_r   <= S_DONE;
                end
                S_DONE: begin
                    // Shared completion cycle for done and err; busy drops afterwards.
                    done_r     <= 1'b0;
                    err_r      <= 1'b0;
                    busy_r     <= 1'b0;
                    boci_r     <= 11'd0;
                    mem_addr_r <= 11'd0;
                    state_r    <= S_IDLE;
                end
                default: begin
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    err_r        <= 1'b0;
                    cpu_search_r <= 1'b0;
                    inval_r      <= 1'b0;
                    downgrade_r  <= 1'b0;
                    mem_re_r     <= 1'b0;
                    mem_we_r     <= 1'b0;
                    fill_we_r    <= 1'b0;
                    boci_r       <= 11'd0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                      = busy_r;
    assign done                      = done_r;
    assign err                       = err_r;
    assign cpu_search                = cpu_search_r;
    assign BOCI                      = boci_r;
    assign invalidate_from_other_cpu = inval_r;
    assign downgrade_other           = downgrade_r;
    assign mem_re                    = mem_re_r;
    assign mem_we                    = mem_we_r;
    assign mem_addr                  = mem_addr_r;
    assign mem_wdata                 = mem_wdata_r;
    assign fill_we                   = fill_we_r;
    assign fill_addr                 = fill_addr_r;
    assign fill_data                 = fill_data_r;
    assign fill_state                = fill_state_r;

endmodule

// File: tb/tb_msi_snoop_ctrl.sv
// Table-driven bench for msi_snoop_ctrl with a behavioural peer cache and memory.
module tb_msi_snoop_ctrl;

    localparam int SNOOP_LAT   = 2;
    localparam int MEM_TIMEOUT = 8;
`ifdef C2C_XFER_EN
    localparam int C2C = 1;
`else
    localparam int C2C = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [10:0] req_addr;
    logic        req_wr;
    logic        busy, done, err, cpu_search;
    logic [10:0] BOCI;
    logic        invalidate_from_other_cpu, downgrade_other;
    logic        snoop_found;
    logic [1:0]  snoop_state;
    logic [63:0] snoop_data;
    logic        mem_re, mem_we;
    logic [10:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_rdy;
    logic [63:0] mem_rdata;
    logic        fill_we;
    logic [10:0] fill_addr;
    logic [63:0] fill_data;
    logic [1:0]  fill_state;

    msi_snoop_ctrl #(.SNOOP_LAT(SNOOP_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_wr(req_wr),
        .busy(busy), .done(done), .err(err), .cpu_search(cpu_search), .BOCI(BOCI),
        .invalidate_from_other_cpu(invalidate_from_other_cpu),
        .downgrade_other(downgrade_other), .snoop_found(snoop_found),
        .snoop_state(snoop_state), .snoop_data(snoop_data), .mem_re(mem_re),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdy(mem_rdy),
        .mem_rdata(mem_rdata), .fill_we(fill_we), .fill_addr(fill_addr),
        .fill_data(fill_data), .fill_state(fill_state)
    );

    always #5 clk = ~clk;

    logic any_out;
    assign any_out = |{busy, done, err, cpu_search, BOCI, invalidate_from_other_cpu,
                       downgrade_other, mem_re, mem_we, mem_addr, mem_wdata, fill_we,
                       fill_addr, fill_data, fill_state};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          n_search, n_re, re_cycles, n_we, n_inv, n_down, n_fill;
        int          n_done, n_err, addr_bad, both_bad, first_busy, busy_end;
        logic [63:0] wdata, fdata;
        logic [10:0] faddr;
        logic [1:0]  fstate;
        bit          ended;
    } obs_t;

    typedef struct {
        logic [10:0] addr;
        logic        wr;
        logic        found;
        logic [1:0]  st;
        logic [63:0] sdata;
        int          lat;
        logic [63:0] mdata;
        int          e_re, e_we, e_inv, e_down;
        logic [63:0] e_fdata;
        logic [1:0]  e_fstate;
    } vec_t;

    // One transaction: drive req, play peer/memory, record what the DUT does.
    // lat = cycles of request before mem_rdy (0 = memory never answers).
    task automatic run_txn(input logic [10:0] a, input logic w, input logic f,
                           input logic [1:0] st, input logic [63:0] sd, input int lat,
                           input logic [63:0] md, input bit hold, output obs_t o);
        int  wcnt;
        bit  prev_re, prev_we;
        o = '{default: 0};
        o.first_busy = -1;
        snoop_found = f; snoop_state = st; snoop_data = sd;
        req_addr = a; req_wr = w; req = 1'b1;
        wcnt = 0; prev_re = 1'b0; prev_we = 1'b0;
        for (int c = 0; c < 300 && !o.ended; c++) begin
            @(negedge clk);
            mem_rdy = 1'b0;
            mem_rdata = 64'hBADD_BADD_BADD_BADD;
            if (o.first_busy < 0) o.first_busy = int'(busy);
            if (cpu_search) o.n_search++;
            if ((cpu_search || invalidate_from_other_cpu || downgrade_other) && BOCI != a)
                o.addr_bad++;
            if ((mem_re || mem_we) && mem_addr != a) o.addr_bad++;
            if (mem_re && mem_we) o.both_bad++;
            if (mem_re && !prev_re) o.n_re++;
            if (mem_re) o.re_cycles++;
            if (mem_we && !prev_we) o.n_we++;
            if (mem_we) o.wdata = mem_wdata;
            if (invalidate_from_other_cpu) o.n_inv++;
            if (downgrade_other) o.n_down++;
            if (fill_we) begin
                o.n_fill++;
                o.fdata = fill_data; o.faddr = fill_addr; o.fstate = fill_state;
            end
            if (done || err) begin
                o.n_done += int'(done);
                o.n_err  += int'(err);
                o.busy_end = int'(busy);
                o.ended = 1'b1;
                if (!hold) req = 1'b0;
            end
            prev_re = mem_re; prev_we = mem_we;
            if (mem_re || mem_we) begin
                wcnt++;
                if (lat > 0 && wcnt == lat) begin
                    mem_rdy = 1'b1;
                    mem_rdata = md;
                    wcnt = 0;
                end
            end
        end
        mem_rdy = 1'b0;
    endtask

    vec_t vecs[8];
    obs_t o, o2;
    int   n, pulses;

    initial begin
        rst_n = 1'b0; req = 1'b0; req_addr = 11'd0; req_wr = 1'b0;
        snoop_found = 1'b0; snoop_state = 2'd0; snoop_data = 64'd0;
        mem_rdy = 1'b0; mem_rdata = 64'd0;

        vecs[0] = '{11'h2A5, 1'b0, 1'b0, 2'd0, 64'h0, 3, 64'h1111_2222_3333_4444,
                    1, 0, 0, 0, 64'h1111_2222_3333_4444, 2'd1};
        vecs[1] = '{11'h155, 1'b1, 1'b1, 2'd1, 64'hAAAA_AAAA_AAAA_AAAA, 2,
                    64'h5555_6666_7777_8888, 1, 0, 1, 0, 64'h5555_6666_7777_8888, 2'd2};
        vecs[2] = '{11'h3C0, 1'b0, 1'b1, 2'd2, 64'hDEAD_BEEF_0000_0001, 3,
                    64'h0BAD_F00D_1234_5678, (C2C != 0) ? 0 : 1, 1, 0, 1,
                    (C2C != 0) ? 64'hDEAD_BEEF_0000_0001 : 64'h0BAD_F00D_1234_5678, 2'd1};
        vecs[3] = '{11'h07F, 1'b1, 1'b1, 2'd2, 64'hCAFE_0000_FFFF_0002, 1,
                    64'h1357_9BDF_2468_ACE0, (C2C != 0) ? 0 : 1, 1, 1, 0,
                    (C2C != 0) ? 64'hCAFE_0000_FFFF_0002 : 64'h1357_9BDF_2468_ACE0, 2'd2};
        vecs[4] = '{11'h400, 1'b0, 1'b1, 2'd1, 64'h7777_0000_7777_0000, 1,
                    64'h0F0F_0F0F_F0F0_F0F0, 1, 0, 0, 0, 64'h0F0F_0F0F_F0F0_F0F0, 2'd1};
        vecs[5] = '{11'h7FF, 1'b1, 1'b1, 2'd3, 64'h3333_3333_3333_3333, 2,
                    64'h0123_4567_89AB_CDEF, 1, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'd2};
        vecs[6] = '{11'h001, 1'b0, 1'b0, 2'd2, 64'h9999_8888_7777_6666, 4,
                    64'hFEDC_BA98_7654_3210, 1, 0, 0, 0, 64'hFEDC_BA98_7654_3210, 2'd1};
        // mem_rdy lands on the timeout cycle: completion must win.
        vecs[7] = '{11'h222, 1'b1, 1'b1, 2'd0, 64'h4444_4444_4444_4444, MEM_TIMEOUT,
                    64'h2222_1111_2222_1111, 1, 0, 0, 0, 64'h2222_1111_2222_1111, 2'd2};

        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", {63'd0, any_out}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs_zero", {63'd0, any_out}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].addr, vecs[i].wr, vecs[i].found, vecs[i].st, vecs[i].sdata,
                    vecs[i].lat, vecs[i].mdata, 1'b0, o);
            chk($sformatf("v%0d_ended", i), 64'(o.ended), 64'd1);
            chk($sformatf("v%0d_search", i), 64'(o.n_search), 64'(SNOOP_LAT));
            chk($sformatf("v%0d_mem_re", i), 64'(o.n_re), 64'(vecs[i].e_re));
            chk($sformatf("v%0d_mem_we", i), 64'(o.n_we), 64'(vecs[i].e_we));
            chk($sformatf("v%0d_inval", i), 64'(o.n_inv), 64'(vecs[i].e_inv));
            chk($sformatf("v%0d_downgrade", i), 64'(o.n_down), 64'(vecs[i].e_down));
            chk($sformatf("v%0d_fill_cnt", i), 64'(o.n_fill), 64'd1);
            chk($sformatf("v%0d_fill_data", i), o.fdata, vecs[i].e_fdata);
            chk($sformatf("v%0d_fill_state", i), 64'(o.fstate), 64'(vecs[i].e_fstate));
            chk($sformatf("v%0d_fill_addr", i), 64'(o.faddr), 64'(vecs[i].addr));
            chk($sformatf("v%0d_done", i), 64'(o.n_done), 64'd1);
            chk($sformatf("v%0d_err", i), 64'(o.n_err), 64'd0);
            chk($sformatf("v%0d_addr", i), 64'(o.addr_bad), 64'd0);
            chk($sformatf("v%0d_re_we_excl", i), 64'(o.both_bad), 64'd0);
            chk($sformatf("v%0d_busy_in_done", i), 64'(o.busy_end), 64'd1);
            if (vecs[i].e_we != 0) chk($sformatf("v%0d_wb_data", i), o.wdata, vecs[i].sdata);
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", i), {63'd0, busy}, 64'd0);
            chk($sformatf("v%0d_boci_idle", i), 64'(BOCI), 64'd0);
        end

        // Memory never answers during MEM_RD: abort after MEM_TIMEOUT cycles.
        run_txn(11'h0C3, 1'b0, 1'b0, 2'd0, 64'd0, 0, 64'd0, 1'b0, o);
        chk("to_ended", 64'(o.ended), 64'd1);
        chk("to_re_cycles", 64'(o.re_cycles), 64'(MEM_TIMEOUT));
        chk("to_err", 64'(o.n_err), 64'd1);
        chk("to_done", 64'(o.n_done), 64'd0);
        chk("to_fill", 64'(o.n_fill), 64'd0);
        @(negedge clk);
        chk("to_busy_after", {63'd0, busy}, 64'd0);
        chk("to_mem_re_after", {63'd0, mem_re}, 64'd0);

        // Asynchronous reset while the writeback is outstanding.
        snoop_found = 1'b1; snoop_state = 2'd2; snoop_data = 64'h5A5A_5A5A_5A5A_5A5A;
        req_addr = 11'h1AB; req_wr = 1'b0; req = 1'b1;
        n = 0;
        while (!mem_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wb_reached", {63'd0, mem_we}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs_zero", {63'd0, any_out}, 64'd0);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(done | err | fill_we | invalidate_from_other_cpu |
                           downgrade_other | busy | cpu_search);
        end
        chk("rst_silent_abort", 64'(pulses), 64'd0);
        run_txn(11'h2A5, 1'b0, 1'b0, 2'd0, 64'd0, 3, 64'h1111_2222_3333_4444, 1'b0, o);
        chk("rst_recover_done", 64'(o.n_done), 64'd1);
        chk("rst_recover_data", o.fdata, 64'h1111_2222_3333_4444);
        @(negedge clk);

        // Back-to-back with req held high across both transactions.
        run_txn(11'h0AA, 1'b0, 1'b0, 2'd0, 64'd0, 2, 64'hAAAA_0000_0000_0001, 1'b1, o);
        chk("b2b_first_done", 64'(o.n_done), 64'd1);
        chk("b2b_first_search", 64'(o.n_search), 64'(SNOOP_LAT));
        @(negedge clk);
        chk("b2b_idle_gap_busy", {63'd0, busy}, 64'd0);
        chk("b2b_idle_gap_search", {63'd0, cpu_search}, 64'd0);
        run_txn(11'h0AA, 1'b0, 1'b0, 2'd0, 64'd0, 2, 64'hAAAA_0000_0000_0002, 1'b0, o2);
        chk("b2b_second_accept", 64'(o2.first_busy), 64'd1);
        chk("b2b_second_search", 64'(o2.n_search), 64'(SNOOP_LAT));
        chk("b2b_second_data", o2.fdata, 64'hAAAA_0000_0000_0002);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            pulses += int'(cpu_search | busy);
        end
        chk("b2b_quiet_after", 64'(pulses), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msi_snoop_ctrl.md
Name: msi_snoop_ctrl

Overview:
Coherence initiator for the 2-CPU MSI system; drives the snoop-side interface of the peer CPU's msi_cache. On a local miss or upgrade it searches the peer cache for the block and writes back a MODIFIED copy to memory. It then invalidates or downgrades the peer copy, obtains the line from the peer or from memory, and produces the fill write into the local cache with the correct MSI state.

Parameters:
SNOOP_LAT, 1, cycles between cpu_search assertion and sampling snoop_found/snoop_state/snoop_data (1..7).
MEM_TIMEOUT, 255, max cycles waiting for mem_rdy before abort with err (8-bit counter).

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
req  input  1  local miss/upgrade request, sampled in IDLE only
req_addr  input  11  block address {tag[4:0],index[5:0]}
req_wr  input  1  1 = write miss/upgrade (needs MODIFIED), 0 = read miss
busy  output  1  high from request acceptance until done/err
done  output  1  1-cycle pulse, transaction complete
err  output  1  1-cycle pulse, memory timeout abort
cpu_search  output  1  peer search strobe
BOCI  output  11  address driven to peer cache (search/invalidate/downgrade)
invalidate_from_other_cpu  output  1  1-cycle pulse, peer sets block INVALID
downgrade_other  output  1  1-cycle pulse, peer sets block SHARED
snoop_found  input  1  peer holds valid copy
snoop_state  input  2  peer block state (INVALID=0, SHARED=1, MODIFIED=2)
snoop_data  input  64  peer line data
mem_re  output  1  memory line read request, held until mem_rdy
mem_we  output  1  memory line write request, held until mem_rdy
mem_addr  output  11  memory line address
mem_wdata  output  64  writeback data
mem_rdy  input  1  memory completion, 1-cycle
mem_rdata  input  64  memory read data, valid with mem_rdy
fill_we  output  1  1-cycle local cache write enable
fill_addr  output  11  local fill address (= captured req_addr)
fill_data  output  64  local fill line
fill_state  output  2  state written: SHARED for read, MODIFIED for write

Behaviour:
- Reset (async): state IDLE; all outputs 0, counters 0, captured registers 0. Reset mid-transaction aborts silently: no done/err/fill/invalidate pulses.
- All outputs registered. BOCI and mem_addr = captured address from acceptance to completion; BOCI = 0 in IDLE.
- IDLE: busy=0. req=1 -> capture req_addr/req_wr, busy=1, go SNOOP. req while busy is ignored; requester holds req until done/err.
- SNOOP: cpu_search=1 for SNOOP_LAT cycles (down-counter); on final cycle sample snoop_found, snoop_state, snoop_data into registers; go DECIDE.
- DECIDE (1 cycle), by sampled peer state:
  - found & MODIFIED -> WB with mem_wdata = sampled snoop_data.
  - found & SHARED & req_wr -> INVAL.
  - found & SHARED & !req_wr, or not found -> MEM_RD.
  - found with state INVALID or 3 is treated as not found.
- WB: mem_we=1 until mem_rdy. Then req_wr -> INVAL, else DOWNGRADE.
- INVAL: invalidate_from_other_cpu pulsed 1 cycle. Next state FILL if peer was MODIFIED and C2C forwarding is enabled, else MEM_RD.
- DOWNGRADE: downgrade_other pulsed 1 cycle. Next state follows the same rule as INVAL.
- MEM_RD: mem_re=1 until mem_rdy; capture mem_rdata; go FILL.
- FILL: fill_we=1 for 1 cycle, fill_data = line source, fill_state = req_wr ? MODIFIED : SHARED; go DONE.
- DONE: done=1 for 1 cycle, busy stays 1 this cycle; next IDLE. A new req is accepted the cycle after DONE.
- Timeout: in WB or MEM_RD the wait counter increments per cycle without mem_rdy. When it reaches MEM_TIMEOUT: drop mem_re/mem_we, pulse err, no fill, return IDLE. The counter clears on entering each wait state. mem_rdy on the same cycle as the timeout wins (normal completion).
- mem_rdy outside WB/MEM_RD is ignored. mem_re and mem_we are never high together.

Optional Feature:
C2C_XFER_EN
- Defined: a peer MODIFIED line is forwarded; after WB and INVAL/DOWNGRADE, FILL uses the sampled snoop_data and MEM_RD is skipped.
- Undefined: after WB and INVAL/DOWNGRADE the controller always goes MEM_RD and fills from mem_rdata.

Test Plan:
- Read miss, peer miss: req addr=0x2A5, req_wr=0, snoop_found=0; mem returns 0x1111_2222_3333_4444 after 3 cycles -> one mem_re txn; fill_we, fill_addr=0x2A5, fill_state=SHARED, data matches; done; no invalidate/downgrade.
- Write miss, peer SHARED: req_wr=1, peer state=1 -> invalidate pulse with BOCI=req_addr, then mem_re, fill_state=MODIFIED; no mem_we.
- Read miss, peer MODIFIED data 0xDEAD_BEEF_0000_0001 -> mem_we with that data, downgrade_other pulse. C2C_XFER_EN on: no mem_re, fill_data = 0xDEAD_BEEF_0000_0001. Off: mem_re issued, fill uses mem_rdata. fill_state=SHARED in both.
- Timeout: MEM_TIMEOUT=8, mem_rdy never asserted in MEM_RD -> mem_re drops after 8 cycles, err pulse, no fill_we, busy=0 next cycle.
- Reset mid-WB: assert rst_n=0 while mem_we=1 -> all outputs 0 immediately; after release, IDLE and a new req completes normally.
- Back-to-back: req held high across two transactions -> second is accepted only the cycle after done; req during busy produces no extra cpu_search.
